// File: rtl/saes32_aes128_seq.sv
// saes32_aes128_seq
// Runs a full AES-128 encryption or decryption by driving an external
// single-byte round unit (ENC1S style) one operation per cycle. Each new
// state word takes four round-unit steps, and each round takes 16 steps.
// The first step of a word folds in the round-key word and the remaining
// steps accumulate into it. Round keys come from an external key store
// that is addressed by the current round number.

module saes32_aes128_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dec,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic [4:0]   fu_fn,
    output logic [31:0]  fu_rs1,
    output logic [31:0]  fu_rs2,
    input  logic [31:0]  fu_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    fsm_t         fsm_d;

    logic [127:0] state_q;
    logic [31:0]  acc_q;
    logic [31:0]  nxt0_q;
    logic [31:0]  nxt1_q;
    logic [31:0]  nxt2_q;
    logic         dec_q;
    logic [3:0]   round_q;
    logic [1:0]   word_q;
    logic [1:0]   step_q;

    logic         last_step;
    logic         final_round;
    logic [1:0]   src_idx;

    assign last_step   = (word_q == 2'd3) && (step_q == 2'd3);
    assign final_round = (round_q == 4'd10);

    // Forward ShiftRows pulls row j from column i+j; the inverse pulls it from column i-j.
    assign src_idx  = dec_q ? (word_q - step_q) : (word_q + step_q);

    assign out_data = state_q;

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state and host handshake outputs.
    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                if (last_step && final_round) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Round-unit issue and key-store address; everything is quiet outside ROUND.
    always_comb begin
        rk_addr = 4'd0;
        fu_fn   = 5'd0;
        fu_rs1  = 32'd0;
        fu_rs2  = 32'd0;
        if (fsm_q == ROUND) begin
            rk_addr = round_q;
            fu_fn   = {1'b0, dec_q, final_round, step_q};
            fu_rs2  = state_q[{src_idx, 5'b00000} +: 32];
            fu_rs1  = (step_q == 2'd0) ? rk_data[{word_q, 5'b00000} +: 32] : acc_q;
        end
    end

    // Block state, accumulator and step/word/round counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            acc_q   <= '0;
            nxt0_q  <= '0;
            nxt1_q  <= '0;
            nxt2_q  <= '0;
            dec_q   <= 1'b0;
            round_q <= 4'd0;
            word_q  <= 2'd0;
            step_q  <= 2'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_data ^ rk_data;
                        dec_q   <= in_dec;
                        round_q <= 4'd1;
                        word_q  <= 2'd0;
                        step_q  <= 2'd0;
                    end
                end
                ROUND: begin
                    step_q <= step_q + 2'd1;
                    if (step_q != 2'd3) begin
                        acc_q <= fu_rd;
                    end else begin
                        word_q <= word_q + 2'd1;
                        case (word_q)
                            2'd0:    nxt0_q <= fu_rd;
                            2'd1:    nxt1_q <= fu_rd;
                            2'd2:    nxt2_q <= fu_rd;
                            default: begin
                                state_q <= {fu_rd, nxt2_q, nxt1_q, nxt0_q};
                                if (!final_round) begin
                                    round_q <= round_q + 4'd1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saes32_aes128_seq.sv
// tb_saes32_aes128_seq
// Bench for the AES-128 round sequencer. It provides a behavioural ENC1S
// round unit, a round-key store with forward keys and equivalent-inverse
// keys, and an independent byte-level AES reference that builds the
// scoreboard of expected blocks.

module tb_saes32_aes128_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_dec;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic [4:0]   fu_fn;
    logic [31:0]  fu_rs1;
    logic [31:0]  fu_rs2;
    logic [31:0]  fu_rd;

    localparam logic [127:0] KEY_C1 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT_C1  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT_C1  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] ek    [16];
    logic [127:0] dk    [16];
    logic         key_dec;
    logic [127:0] exp_q [$];
    int           cycle;
    int           checks;
    int           errors;

    saes32_aes128_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dec    (in_dec),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .fu_fn     (fu_fn),
        .fu_rs1    (fu_rs1),
        .fu_rs2    (fu_rs2),
        .fu_rd     (fu_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- GF(2^8) and AES reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = inv ? isbox[s[8*k +: 8]] : sbox[s[8*k +: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[8*(4*c + r) +: 8] = s[8*(4*src + r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   base [4];
        logic [7:0]   acc;
        if (inv) begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end else begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                acc = 8'h00;
                for (int m = 0; m < 4; m++) begin
                    acc = acc ^ gmul(s[8*(4*c + m) +: 8], base[(m - k + 4) % 4]);
                end
                o[8*(4*c + k) +: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[7:0] = t[7:0] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            ek[r] = '0;
            dk[r] = '0;
        end
        for (int r = 0; r < 11; r++) ek[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
        dk[0] = ek[10];
        for (int r = 1; r < 10; r++) dk[r] = mix_columns(ek[10-r], 1'b1);
        dk[10] = ek[0];
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ ek[0];
        for (int r = 1; r < 10; r++) begin
            s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ ek[r];
        end
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ ek[10];
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ ek[10];
        for (int r = 9; r >= 1; r--) begin
            s = mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ ek[r], 1'b1);
        end
        return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ ek[0];
    endfunction

    // ---------------- external round unit and key store ----------------
    function automatic logic [31:0] round_unit(input logic [4:0] fn, input logic [31:0] rs1,
                                               input logic [31:0] rs2);
        logic [7:0]  x;
        logic [7:0]  y;
        logic [31:0] m;
        logic [31:0] rot;
        x = rs2[8*int'(fn[1:0]) +: 8];
        if (!fn[3]) begin
            y = sbox[x];
            m = fn[2] ? {24'h0, y} : {gmul(y, 8'h03), y, y, gmul(y, 8'h02)};
        end else begin
            y = isbox[x];
            m = fn[2] ? {24'h0, y}
                      : {gmul(y, 8'h0b), gmul(y, 8'h0d), gmul(y, 8'h09), gmul(y, 8'h0e)};
        end
        case (fn[1:0])
            2'd0:    rot = m;
            2'd1:    rot = {m[23:0], m[31:24]};
            2'd2:    rot = {m[15:0], m[31:16]};
            default: rot = {m[7:0], m[31:8]};
        endcase
        return rs1 ^ rot;
    endfunction

    always_comb fu_rd = round_unit(fu_fn, fu_rs1, fu_rs2);
    always_comb rk_data = key_dec ? dk[rk_addr] : ek[rk_addr];

    // ---------------- driver helpers (no checking) ----------------
    task automatic start_block(input logic dec, input logic [127:0] data,
                               output bit accepted, output int t_acc);
        int n;
        n = 0;
        key_dec  = dec;
        in_dec   = dec;
        in_data  = data;
        in_valid = 1'b1;
        exp_q.push_back(dec ? aes_dec(data) : aes_enc(data));
        while (in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        accepted = (in_ready === 1'b1);
        t_acc    = cycle + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int limit, output bit timed_out);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        timed_out = (out_valid !== 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        if (rk_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_rk_addr: got %h expected 0", rk_addr); end
        if (fu_fn !== 5'h0) begin errors++; $display("[TB] FAIL reset_fu_fn: got %h expected 0", fu_fn); end
        if (fu_rs1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_fu_rs1: got %h expected 0", fu_rs1); end
        if (fu_rs2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_fu_rs2: got %h expected 0", fu_rs2); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_known_answer(input logic dec, input logic [127:0] data,
                                     input logic [127:0] kat);
        bit           acc_ok;
        bit           to;
        int           t_acc;
        int           r, i, j, src;
        int           fn_bad, rs1_bad, rs2_bad, rk_bad, ov_bad, r10_bad;
        logic [4:0]   exp_fn;
        logic [127:0] whitened;
        logic [127:0] rk_exp;
        logic [31:0]  prev_rd;
        logic [31:0]  r10 [4][4];
        logic [127:0] exp_v;
        fn_bad = 0; rs1_bad = 0; rs2_bad = 0; rk_bad = 0; ov_bad = 0; r10_bad = 0;
        prev_rd = 32'h0;
        out_ready = 1'b1;
        whitened = data ^ (dec ? dk[0] : ek[0]);
        start_block(dec, data, acc_ok, t_acc);
        checks++;
        if (!acc_ok) begin errors++; $display("[TB] FAIL kat_accept: got in_ready=%b expected 1", in_ready); end
        for (int k = 0; k < 160; k++) begin
            r = k / 16 + 1;
            i = (k / 4) % 4;
            j = k % 4;
            src = dec ? ((i - j + 4) % 4) : ((i + j) % 4);
            exp_fn = {1'b0, dec, (r == 10), 2'(j)};
            rk_exp = dec ? dk[r] : ek[r];
            if (fu_fn !== exp_fn) fn_bad++;
            if (rk_addr !== 4'(r)) rk_bad++;
            if (out_valid !== 1'b0) ov_bad++;
            if (j == 0 && fu_rs1 !== rk_exp[32*i +: 32]) rs1_bad++;
            if (j != 0 && fu_rs1 !== prev_rd) rs1_bad++;
            if (r == 1 && fu_rs2 !== whitened[32*src +: 32]) rs2_bad++;
            if (r == 10) r10[i][j] = fu_rs2;
            prev_rd = fu_rd;
            @(negedge clk);
        end
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                src = dec ? ((a - b + 4) % 4) : ((a + b) % 4);
                if (r10[a][b] !== r10[src][0]) r10_bad++;
            end
        end
        checks += 6;
        if (fn_bad != 0) begin errors++; $display("[TB] FAIL trace_fu_fn dec=%b: got %0d bad cycles expected 0", dec, fn_bad); end
        if (rk_bad != 0) begin errors++; $display("[TB] FAIL trace_rk_addr dec=%b: got %0d bad cycles expected 0", dec, rk_bad); end
        if (ov_bad != 0) begin errors++; $display("[TB] FAIL trace_early_valid dec=%b: got %0d bad cycles expected 0", dec, ov_bad); end
        if (rs1_bad != 0) begin errors++; $display("[TB] FAIL trace_fu_rs1 dec=%b: got %0d bad cycles expected 0", dec, rs1_bad); end
        if (rs2_bad != 0) begin errors++; $display("[TB] FAIL trace_rs2_round1 dec=%b: got %0d bad cycles expected 0", dec, rs2_bad); end
        if (r10_bad != 0) begin errors++; $display("[TB] FAIL trace_rs2_round10 dec=%b: got %0d bad selections expected 0", dec, r10_bad); end
        wait_out_valid(50, to);
        checks += 3;
        if (to || (cycle - t_acc) != 160) begin
            errors++;
            $display("[TB] FAIL kat_latency dec=%b: got %0d cycles expected 160", dec, cycle - t_acc);
        end
        if (out_data !== kat) begin errors++; $display("[TB] FAIL kat_data dec=%b: got %h expected %h", dec, out_data, kat); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
        if (out_data !== exp_v) begin errors++; $display("[TB] FAIL kat_scoreboard dec=%b: got %h expected %h", dec, out_data, exp_v); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL kat_return_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit           acc_ok;
        bit           to;
        int           t_acc;
        int           bad_data, bad_ready, bad_valid;
        logic [127:0] data;
        logic [127:0] exp_v;
        bad_data = 0; bad_ready = 0; bad_valid = 0;
        out_ready = 1'b0;
        data = {$urandom, $urandom, $urandom, $urandom};
        start_block(1'b0, data, acc_ok, t_acc);
        wait_out_valid(200, to);
        checks++;
        if (to || !acc_ok) begin errors++; $display("[TB] FAIL bp_reach_done: got valid=%b expected 1", out_valid); end
        exp_v = (exp_q.size() > 0) ? exp_q[0] : ~out_data;
        for (int n = 0; n < 20; n++) begin
            if (out_data !== exp_v) bad_data++;
            if (in_ready !== 1'b0) bad_ready++;
            if (out_valid !== 1'b1) bad_valid++;
            in_valid = 1'($urandom_range(0, 1));
            in_dec   = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks += 3;
        if (bad_data != 0) begin errors++; $display("[TB] FAIL bp_data_stable: got %0d bad cycles expected 0", bad_data); end
        if (bad_ready != 0) begin errors++; $display("[TB] FAIL bp_in_ready_low: got %0d bad cycles expected 0", bad_ready); end
        if (bad_valid != 0) begin errors++; $display("[TB] FAIL bp_valid_held: got %0d bad cycles expected 0", bad_valid); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
        checks++;
        if (out_data !== exp_v) begin errors++; $display("[TB] FAIL bp_scoreboard: got %h expected %h", out_data, exp_v); end
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_same_cycle: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || rk_addr !== 4'h0) begin
            errors++;
            $display("[TB] FAIL bp_no_queued_start: got ready=%b rk_addr=%h expected ready=1 rk_addr=0", in_ready, rk_addr);
        end
    endtask

    task automatic test_reset_midround();
        bit           acc_ok;
        bit           to;
        int           t_acc;
        logic [127:0] exp_v;
        out_ready = 1'b1;
        start_block(1'b0, PT_C1, acc_ok, t_acc);
        repeat (50) @(negedge clk);
        checks++;
        if (rk_addr !== 4'd4) begin errors++; $display("[TB] FAIL midround_position: got rk_addr=%h expected 4", rk_addr); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_handshake: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        if (out_data !== 128'h0) begin errors++; $display("[TB] FAIL abort_out_data: got %h expected 0", out_data); end
        if (rk_addr !== 4'h0) begin errors++; $display("[TB] FAIL abort_rk_addr: got %h expected 0", rk_addr); end
        if (fu_fn !== 5'h0 || fu_rs1 !== 32'h0 || fu_rs2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_fu: got fn=%h rs1=%h rs2=%h expected all 0", fu_fn, fu_rs1, fu_rs2);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_block(1'b0, PT_C1, acc_ok, t_acc);
        wait_out_valid(200, to);
        checks += 3;
        if (to || (cycle - t_acc) != 160) begin
            errors++;
            $display("[TB] FAIL post_abort_latency: got %0d cycles expected 160", cycle - t_acc);
        end
        if (out_data !== CT_C1) begin errors++; $display("[TB] FAIL post_abort_data: got %h expected %h", out_data, CT_C1); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
        if (out_data !== exp_v) begin errors++; $display("[TB] FAIL post_abort_scoreboard: got %h expected %h", out_data, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit           acc_ok;
        bit           to;
        int           t_acc;
        int           prev_acc;
        logic [127:0] data;
        logic [127:0] exp_v;
        out_ready = 1'b1;
        prev_acc = 0;
        for (int b = 0; b < 8; b++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            start_block(1'(b % 2), data, acc_ok, t_acc);
            checks++;
            if (!acc_ok) begin errors++; $display("[TB] FAIL b2b_accept[%0d]: got in_ready=%b expected 1", b, in_ready); end
            if (b > 0) begin
                checks++;
                if (t_acc - prev_acc != 162) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles expected 162", b, t_acc - prev_acc);
                end
            end
            prev_acc = t_acc;
            wait_out_valid(200, to);
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
            checks++;
            if (to || out_data !== exp_v) begin
                errors++;
                $display("[TB] FAIL b2b_result[%0d] dec=%0d: got %h expected %h", b, b % 2, out_data, exp_v);
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got ready=%b pending=%0d expected ready=1 pending=0", in_ready, exp_q.size());
        end
    endtask

    // Watchdog so a stuck handshake cannot hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $fatal(1, "[TB] aborted by watchdog");
    end

    // Main sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_dec    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        key_dec   = 1'b0;
        build_tables();
        expand_key(KEY_C1);
        test_reset();
        test_known_answer(1'b0, PT_C1, CT_C1);
        test_known_answer(1'b1, CT_C1, PT_C1);
        test_backpressure();
        test_reset_midround();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
